// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and instruction sizing.
package cpu_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FULL  = 1'b1
  } fetch_state_e;

  // Byte step between consecutive instruction words of a given width.
  function automatic int unsigned inst_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned INST_BYTES = inst_bytes(32);

endpackage

// File: rtl/inst_fifo.sv
// Circular instruction queue: one write port (tail), one read port (head),
// synchronous flush that drops every entry in a single edge.
module inst_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity lives entirely in the
  // pointers and count, so the RAM can map onto plain flops or a register file.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues one read per cycle to instruction memory,
// queues the responses with their PCs, and redirects on a taken branch.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [DATA_W-1:0]      imem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [DATA_W-1:0]      inst_out,
  output logic [ADDR_W-1:0]      pc_out,
  input  logic                   br_taken,
  input  logic [ADDR_W-1:0]      br_target,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned       CW      = $clog2(DEPTH) + 1;
  localparam int unsigned       EW      = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(inst_bytes(DATA_W));
  localparam logic [CW:0]       DEPTH_P = (CW + 1)'(DEPTH);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              issue, push, pop;
  logic              fifo_full, fifo_empty;
  logic [CW:0]       pending, pending_next;
  logic [EW-1:0]     head;

  // A redirect suppresses both queue ports so the flush sees a clean edge.
  assign pop          = inst_valid && inst_ready && !br_taken;
  assign push         = inflight && !br_taken;

  // Entries held plus the response still on its way back.
  assign pending      = {1'b0, occupancy} + {{CW{1'b0}}, inflight};
  assign issue        = rst && (state == FETCH) && !br_taken && !fifo_full
                        && (pending < DEPTH_P);
  assign pending_next = pending + {{CW{1'b0}}, issue};

  assign imem_req     = issue;
  assign imem_addr    = fetch_pc;

  assign inst_valid   = !fifo_empty;
  assign inst_out     = head[DATA_W-1:0];
  assign pc_out       = head[EW-1:DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      state <= state_next;
      if (br_taken) begin
        fetch_pc <= br_target;
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          fetch_pc    <= fetch_pc + PC_STEP;
          inflight_pc <= fetch_pc;
        end
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (!pop && pending_next == DEPTH_P) state_next = FULL;
      FULL:    if (pop) state_next = FETCH;
      default: state_next = FETCH;
    endcase
    if (br_taken) state_next = FETCH;
  end

  inst_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (br_taken),
    .wdata ({inflight_pc, imem_rdata}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, fill/stall, streaming, branch
// flush, address wrap and mid-operation reset, cycle by cycle.
module tb_inst_fetch_queue;
  import cpu_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata = '0;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_out;
  logic [ADDR_W-1:0] pc_out;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [2:0]        occupancy;

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch_queue #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE3A0_2007;
      32'h0000_0004: return 32'hE1A0_3002;
      32'h0000_0008: return 32'hE082_5003;
      default:       return 32'h5A00_0000 ^ a;
    endcase
  endfunction

  // Single-cycle instruction memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    inst_ready = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    tick();
    tick();
    check("rst_req",   imem_req,   1'b0);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_occ",   occupancy,  3'd0);
    check("rst_addr",  imem_addr,  32'h0);
    check("rst_state", dut.state,  FETCH);

    // Cycle 1 after release: first request at RESET_PC.
    rst = 1'b1;
    #1;
    check("c1_req",  imem_req,  1'b1);
    check("c1_addr", imem_addr, 32'h0);
    tick();
    check("c2_addr",  imem_addr,  32'h4);
    check("c2_valid", inst_valid, 1'b0);
    tick();
    check("c3_valid", inst_valid, 1'b1);
    check("c3_inst",  inst_out,   32'hE3A0_2007);
    check("c3_pc",    pc_out,     32'h0);
    tick();
    check("c4_req",  imem_req,  1'b1);
    check("c4_addr", imem_addr, 32'hC);
    tick();
    check("c5_req", imem_req, 1'b0);
    tick();
    check("c6_occ",   occupancy, 3'd4);
    check("c6_state", dut.state, FULL);
    check("c6_req",   imem_req,  1'b0);
    check("c6_inst",  inst_out,  32'hE3A0_2007);

    // One pop releases FULL; ready stays high to stream the rest.
    inst_ready = 1'b1;
    tick();
    check("c7_occ",  occupancy, 3'd3);
    check("c7_req",  imem_req,  1'b1);
    check("c7_addr", imem_addr, 32'h10);
    check("c7_inst", inst_out,  32'hE1A0_3002);
    check("c7_pc",   pc_out,    32'h4);
    tick();
    check("c8_inst", inst_out,  32'hE082_5003);
    check("c8_pc",   pc_out,    32'h8);
    check("c8_addr", imem_addr, 32'h14);
    tick();
    check("c9_inst", inst_out, 32'h5A00_000C);
    check("c9_pc",   pc_out,   32'hC);
    tick();
    check("c10_inst", inst_out,  32'h5A00_0010);
    check("c10_pc",   pc_out,    32'h10);
    check("c10_occ",  occupancy, 3'd2);

    // Branch while a response is in flight and a pop is requested.
    br_taken  = 1'b1;
    br_target = 32'h100;
    #1;
    check("br1_req",   imem_req,   1'b0);
    check("br1_valid", inst_valid, 1'b1);
    tick();
    br_taken   = 1'b0;
    inst_ready = 1'b0;
    #1;
    check("br1_occ",   occupancy,  3'd0);
    check("br1_empty", inst_valid, 1'b0);
    check("br1_nreq",  imem_req,   1'b1);
    check("br1_naddr", imem_addr,  32'h100);
    tick();
    check("br1_occ2",   occupancy,  3'd0);
    check("br1_empty2", inst_valid, 1'b0);
    tick();
    check("br1_valid3", inst_valid, 1'b1);
    check("br1_inst",   inst_out,   32'h5A00_0100);
    check("br1_pc",     pc_out,     32'h100);

    // Redirect to 0 and stream three instructions with ready held high.
    br_taken   = 1'b1;
    br_target  = 32'h0;
    inst_ready = 1'b1;
    #1;
    check("br2_req", imem_req, 1'b0);
    tick();
    br_taken = 1'b0;
    #1;
    check("s0_addr",  imem_addr,  32'h0);
    check("s0_valid", inst_valid, 1'b0);
    tick();
    check("s1_addr",  imem_addr,  32'h4);
    check("s1_occ",   occupancy,  3'd0);
    tick();
    check("s2_occ",  occupancy, 3'd1);
    check("s2_inst", inst_out,  32'hE3A0_2007);
    check("s2_pc",   pc_out,    32'h0);
    tick();
    check("s3_inst", inst_out, 32'hE1A0_3002);
    check("s3_pc",   pc_out,   32'h4);
    tick();
    check("s4_inst", inst_out, 32'hE082_5003);
    check("s4_pc",   pc_out,   32'h8);

    // Fetch address wraps past the top of the address space.
    br_taken   = 1'b1;
    br_target  = 32'hFFFF_FFFC;
    inst_ready = 1'b0;
    tick();
    br_taken = 1'b0;
    #1;
    check("wrap_req",   imem_req,  1'b1);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", imem_addr, 32'h0);
    tick();
    check("wrap_inst", inst_out,  32'hA5FF_FFFC);
    check("wrap_pc",   pc_out,    32'hFFFF_FFFC);
    check("wrap_occ",  occupancy, 3'd1);
    tick();
    tick();
    check("pre_rst_occ", occupancy, 3'd3);

    // Mid-operation reset empties the queue at once.
    rst = 1'b0;
    #1;
    check("mrst_valid", inst_valid, 1'b0);
    check("mrst_occ",   occupancy,  3'd0);
    check("mrst_req",   imem_req,   1'b0);
    check("mrst_addr",  imem_addr,  32'h0);
    tick();
    rst = 1'b1;
    #1;
    check("r1_req",  imem_req,  1'b1);
    check("r1_addr", imem_addr, 32'h0);
    tick();
    check("r2_valid", inst_valid, 1'b0);
    tick();
    check("r3_valid", inst_valid, 1'b1);
    check("r3_inst",  inst_out,   32'hE3A0_2007);
    check("r3_pc",    pc_out,     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, instruction width in bits.
REQ-002 The block SHALL take parameter ADDR_W, default 32, byte-address width.
REQ-003 The block SHALL take parameter DEPTH, default 4, queue entries; a power of 2 and at least 2.
REQ-004 The block SHALL take parameter RESET_PC, default 0, first fetch address.
REQ-005 One clock and one reset: asynchronous, active-low; ports are named clk and rst.
REQ-006 The ports SHALL be, in order:
- clk  in  1  clock, rising edge.
- rst  in  1  async active-low reset.
- imem_req  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  read byte address.
- imem_rdata  in  DATA_W  read data, valid exactly 1 cycle after imem_req.
- inst_valid  out  1  head entry available to the CPU.
- inst_ready  in  1  CPU accepts the head entry.
- inst_out  out  DATA_W  head instruction.
- pc_out  out  ADDR_W  address of the head instruction.
- br_taken  in  1  redirect request from execute.
- br_target  in  ADDR_W  redirect address.
- occupancy  out  $clog2(DEPTH)+1  entries held.

Function
REQ-007 fetch_pc SHALL advance by DATA_W/8 per issued request, wrapping modulo 2^ADDR_W.
REQ-008 The FSM SHALL have states FETCH and FULL.
REQ-009 In FETCH, imem_req=1 SHALL be driven when occupancy + in-flight < DEPTH, with imem_addr=fetch_pc.
REQ-010 The FSM SHALL enter FULL when occupancy + in-flight = DEPTH with no pop, and SHALL return to FETCH on the first pop.
REQ-011 No more than one request SHALL be in flight; each request is tracked by one in-flight flag and its PC.
REQ-012 The response SHALL be written to the tail at the edge ending the cycle after the request; inst_valid rises the following cycle, giving 2-cycle request-to-valid latency and no bypass.
REQ-013 A pop SHALL occur when inst_valid && inst_ready; the head advances and occupancy decrements at that edge.
REQ-014 A simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-015 inst_ready while inst_valid=0 SHALL have no effect.
REQ-016 br_taken=1 SHALL, at that edge, empty the queue, kill any in-flight response, set fetch_pc=br_target, and force FETCH.
REQ-017 br_taken SHALL win over a simultaneous pop or push: neither takes effect.
REQ-018 imem_req SHALL be 0 in the br_taken cycle, and imem_addr=br_target SHALL issue the next cycle.
REQ-019 inst_out and pc_out SHALL be meaningful only while inst_valid=1, and SHALL be held stable while inst_valid && !inst_ready.

Reset
REQ-020 While rst=0: imem_req=0, inst_valid=0, occupancy=0, in-flight cleared, FSM=FETCH, fetch_pc=RESET_PC, imem_addr=RESET_PC.
REQ-021 Reset asserted mid-operation SHALL immediately discard all entries and any in-flight response.
REQ-022 The first request SHALL issue in the first cycle after rst deasserts, at RESET_PC.
REQ-023 Queue data storage does not need to be reset.

Structure
REQ-024 The FSM state enum and the INST_BYTES constant SHALL live in the shared package cpu_pkg.
REQ-025 Storage SHALL be one sub-module inst_fifo, parametrised by DATA_W+ADDR_W and DEPTH, with push, pop, flush, full, empty and count.
REQ-026 The fetch FSM, PC logic and in-flight tracking SHALL sit in inst_fetch_queue.

Verification
REQ-027 Reset release with memory returning E3A02007 at 0x0 -> imem_req at 0x0 in cycle 1; inst_valid=1, inst_out=E3A02007, pc_out=0x0 in cycle 3.
REQ-028 inst_ready=0 with DEPTH=4 -> addresses 0x0..0xC fetched; occupancy=4, FSM=FULL, imem_req=0; one pop -> next request at 0x10.
REQ-029 Stream E3A02007, E1A03002, E0825003 with inst_ready=1 -> all delivered in order with pc_out 0x0, 0x4, 0x8 on consecutive cycles after fill.
REQ-030 br_taken with br_target=0x100 while an in-flight response and a pop coincide -> occupancy=0, stale response dropped, next imem_addr=0x100.
REQ-031 fetch_pc=0xFFFFFFFC -> next request at 0x00000000.
REQ-032 rst asserted with occupancy=3 -> inst_valid=0 and occupancy=0 in the same cycle; refetch from RESET_PC after release.
